// File: rtl/mem_lsu.sv
// Memory-access stage: passes non-memory ops straight through, runs a
// req/ack transaction for loads and stores while holding the pipe stalled,
// and produces extended load data plus alignment / bus-timeout flags.
module mem_lsu #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_i,
  input  logic [4:0]  mem_rw_i,
  input  logic        mem_wreg_i,
  input  logic [31:0] mem_wdata_i,
  input  logic [3:0]  mem_op_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_sdata_i,
  output logic        dbus_req_o,
  output logic        dbus_we_o,
  output logic [31:0] dbus_addr_o,
  output logic [3:0]  dbus_sel_o,
  output logic [31:0] dbus_wdata_o,
  input  logic [31:0] dbus_rdata_i,
  input  logic        dbus_ack_i,
  output logic [31:0] pc_o,
  output logic [4:0]  wb_rw_o,
  output logic        wb_wreg_o,
  output logic [31:0] wb_wdata_o,
  output logic        stall_req_o,
  output logic        excp_align_o,
  output logic        bus_err_o
);

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

  typedef struct packed {
    logic  load;
    logic  store;
    logic  sext;
    size_t size;
    logic  misalign;
  } dec_t;

  state_t      state, state_nxt;
  logic [7:0]  cnt;
  logic [31:0] result;
  logic        err;
  dec_t        dec;
  logic [3:0]  sel;
  logic [31:0] st_data;
  logic [31:0] ld_ext;
  logic        mem_op;
  logic        timeout;

  // Decode the op into load/store, access size and alignment.
  always_comb begin
    dec = '0;
    unique case (mem_op_i)
      OP_LB:   begin dec.load  = 1'b1; dec.sext = 1'b1; dec.size = SZ_B; end
      OP_LBU:  begin dec.load  = 1'b1; dec.size = SZ_B; end
      OP_LH:   begin dec.load  = 1'b1; dec.sext = 1'b1; dec.size = SZ_H; end
      OP_LHU:  begin dec.load  = 1'b1; dec.size = SZ_H; end
      OP_LW:   begin dec.load  = 1'b1; dec.size = SZ_W; end
      OP_SB:   begin dec.store = 1'b1; dec.size = SZ_B; end
      OP_SH:   begin dec.store = 1'b1; dec.size = SZ_H; end
      OP_SW:   begin dec.store = 1'b1; dec.size = SZ_W; end
      default: dec = '0;
    endcase
    if (dec.size == SZ_H) dec.misalign = mem_addr_i[0];
    else if (dec.size == SZ_W) dec.misalign = |mem_addr_i[1:0];
  end

  assign mem_op = dec.load | dec.store;

  // Big-endian lane enables and store data replicated across lanes.
  always_comb begin
    sel     = 4'b0000;
    st_data = mem_sdata_i;
    unique case (dec.size)
      SZ_B: begin
        sel     = 4'b1000 >> mem_addr_i[1:0];
        st_data = {4{mem_sdata_i[7:0]}};
      end
      SZ_H: begin
        sel     = mem_addr_i[1] ? 4'b0011 : 4'b1100;
        st_data = {2{mem_sdata_i[15:0]}};
      end
      default: sel = 4'b1111;
    endcase
  end

  // Pick the addressed lane out of the read word and extend it.
  always_comb begin
    ld_ext = dbus_rdata_i;
    unique case (dec.size)
      SZ_B: begin
        logic [7:0] b;
        unique case (mem_addr_i[1:0])
          2'd0:    b = dbus_rdata_i[31:24];
          2'd1:    b = dbus_rdata_i[23:16];
          2'd2:    b = dbus_rdata_i[15:8];
          default: b = dbus_rdata_i[7:0];
        endcase
        ld_ext = {{24{dec.sext & b[7]}}, b};
      end
      SZ_H: begin
        logic [15:0] h;
        h      = mem_addr_i[1] ? dbus_rdata_i[15:0] : dbus_rdata_i[31:16];
        ld_ext = {{16{dec.sext & h[15]}}, h};
      end
      default: ld_ext = dbus_rdata_i;
    endcase
  end

  assign timeout = (cnt == TO_LAST);

  // State, wait counter, captured load data and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      result <= '0;
      err    <= 1'b0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: begin
          cnt <= '0;
          err <= 1'b0;
        end
        ACCESS: begin
          if (dbus_ack_i)   result <= ld_ext;
          else if (timeout) err    <= 1'b1;
          else              cnt    <= cnt + 8'd1;
        end
        default: ;
      endcase
    end
  end

  // Next-state: ack beats a simultaneous timeout; DONE lasts one cycle.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (mem_op && !dec.misalign) state_nxt = ACCESS;
      ACCESS:  if (dbus_ack_i || timeout)   state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode; everything is gated to zero while reset is held.
  always_comb begin
    pc_o         = pc_i;
    wb_rw_o      = mem_rw_i;
    wb_wdata_o   = mem_wdata_i;
    wb_wreg_o    = 1'b0;
    stall_req_o  = 1'b0;
    excp_align_o = 1'b0;
    bus_err_o    = 1'b0;
    dbus_req_o   = 1'b0;
    dbus_we_o    = 1'b0;
    dbus_addr_o  = '0;
    dbus_sel_o   = '0;
    dbus_wdata_o = '0;
    unique case (state)
      IDLE: begin
        if (!mem_op)           wb_wreg_o    = mem_wreg_i;
        else if (dec.misalign) excp_align_o = 1'b1;
        else                   stall_req_o  = 1'b1;
      end
      ACCESS: begin
        dbus_req_o   = 1'b1;
        dbus_we_o    = dec.store;
        dbus_addr_o  = {mem_addr_i[31:2], 2'b00};
        dbus_sel_o   = sel;
        dbus_wdata_o = st_data;
        stall_req_o  = 1'b1;
      end
      default: begin
        if (err) begin
          bus_err_o = 1'b1;
        end else begin
          wb_wreg_o = mem_wreg_i;
          if (dec.load) wb_wdata_o = result;
        end
      end
    endcase
    if (!rst) begin
      pc_o         = '0;
      wb_rw_o      = '0;
      wb_wdata_o   = '0;
      wb_wreg_o    = 1'b0;
      stall_req_o  = 1'b0;
      excp_align_o = 1'b0;
      bus_err_o    = 1'b0;
      dbus_req_o   = 1'b0;
      dbus_we_o    = 1'b0;
      dbus_addr_o  = '0;
      dbus_sel_o   = '0;
      dbus_wdata_o = '0;
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: a transaction-level model derives the expected
// per-cycle outputs; two DUTs cover the default and a short timeout.
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_i, mem_wdata_i, mem_addr_i, mem_sdata_i, dbus_rdata_i;
  logic [4:0]  mem_rw_i;
  logic        mem_wreg_i, dbus_ack_i;
  logic [3:0]  mem_op_i;

  logic        a_req, a_we, a_wreg, a_stall, a_align, a_berr;
  logic [31:0] a_addr, a_dw, a_pc, a_wdata;
  logic [3:0]  a_sel;
  logic [4:0]  a_rw;
  logic        b_req, b_we, b_wreg, b_stall, b_align, b_berr;
  logic [31:0] b_addr, b_dw, b_pc, b_wdata;
  logic [3:0]  b_sel;
  logic [4:0]  b_rw;

  always #5 clk = ~clk;

  mem_lsu #(.TIMEOUT(255)) u_dut_a (
    .clk(clk), .rst(rst), .pc_i(pc_i), .mem_rw_i(mem_rw_i), .mem_wreg_i(mem_wreg_i),
    .mem_wdata_i(mem_wdata_i), .mem_op_i(mem_op_i), .mem_addr_i(mem_addr_i),
    .mem_sdata_i(mem_sdata_i), .dbus_req_o(a_req), .dbus_we_o(a_we), .dbus_addr_o(a_addr),
    .dbus_sel_o(a_sel), .dbus_wdata_o(a_dw), .dbus_rdata_i(dbus_rdata_i),
    .dbus_ack_i(dbus_ack_i), .pc_o(a_pc), .wb_rw_o(a_rw), .wb_wreg_o(a_wreg),
    .wb_wdata_o(a_wdata), .stall_req_o(a_stall), .excp_align_o(a_align), .bus_err_o(a_berr));

  mem_lsu #(.TIMEOUT(4)) u_dut_b (
    .clk(clk), .rst(rst), .pc_i(pc_i), .mem_rw_i(mem_rw_i), .mem_wreg_i(mem_wreg_i),
    .mem_wdata_i(mem_wdata_i), .mem_op_i(mem_op_i), .mem_addr_i(mem_addr_i),
    .mem_sdata_i(mem_sdata_i), .dbus_req_o(b_req), .dbus_we_o(b_we), .dbus_addr_o(b_addr),
    .dbus_sel_o(b_sel), .dbus_wdata_o(b_dw), .dbus_rdata_i(dbus_rdata_i),
    .dbus_ack_i(dbus_ack_i), .pc_o(b_pc), .wb_rw_o(b_rw), .wb_wreg_o(b_wreg),
    .wb_wdata_o(b_wdata), .stall_req_o(b_stall), .excp_align_o(b_align), .bus_err_o(b_berr));

  // Outputs of whichever DUT is under test.
  logic        use_b = 1'b0;
  logic        c_req, c_we, c_wreg, c_stall, c_align, c_berr;
  logic [31:0] c_addr, c_dw, c_pc, c_wdata;
  logic [3:0]  c_sel;
  logic [4:0]  c_rw;
  assign c_req   = use_b ? b_req   : a_req;
  assign c_we    = use_b ? b_we    : a_we;
  assign c_wreg  = use_b ? b_wreg  : a_wreg;
  assign c_stall = use_b ? b_stall : a_stall;
  assign c_align = use_b ? b_align : a_align;
  assign c_berr  = use_b ? b_berr  : a_berr;
  assign c_addr  = use_b ? b_addr  : a_addr;
  assign c_dw    = use_b ? b_dw    : a_dw;
  assign c_pc    = use_b ? b_pc    : a_pc;
  assign c_wdata = use_b ? b_wdata : a_wdata;
  assign c_sel   = use_b ? b_sel   : a_sel;
  assign c_rw    = use_b ? b_rw    : a_rw;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  function automatic int op_size(input logic [3:0] op);
    case (op)
      4'd1, 4'd2, 4'd6: return 1;
      4'd3, 4'd4, 4'd7: return 2;
      4'd5, 4'd8:       return 4;
      default:          return 0;
    endcase
  endfunction

  function automatic logic m_store(input logic [3:0] op);
    return (op >= 4'd6) && (op <= 4'd8);
  endfunction

  function automatic logic m_misal(input logic [3:0] op, input logic [31:0] addr);
    int a = int'(addr[1:0]);
    int sz = op_size(op);
    return (sz > 1) && ((a % sz) != 0);
  endfunction

  function automatic logic [3:0] m_sel(input logic [3:0] op, input logic [31:0] addr);
    logic [3:0] s = '0;
    int a = int'(addr[1:0]);
    int sz = op_size(op);
    for (int k = 0; k < 4; k++)
      if (k >= a && k < a + sz) s[3-k] = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] m_dwdata(input logic [3:0] op, input logic [31:0] sd);
    case (op_size(op))
      1:       return {4{sd[7:0]}};
      2:       return {2{sd[15:0]}};
      default: return sd;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [3:0] op, input logic [31:0] addr,
                                         input logic [31:0] rd);
    int a = int'(addr[1:0]);
    int sz = op_size(op);
    logic [31:0] mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
    logic [31:0] v = (rd >> (8 * (4 - a - sz))) & mask;
    if ((op == 4'd1 || op == 4'd3) && v[8*sz-1]) v = v | ~mask;
    return v;
  endfunction

  // ---------------- per-cycle expectations ----------------
  logic        chk_en = 1'b0, exp_zero = 1'b0;
  logic        exp_req, exp_we, exp_stall, exp_wreg, exp_align, exp_err;
  logic        exp_chk_wdata, exp_chk_prw;
  logic [31:0] exp_addr, exp_dw, exp_wdata;
  logic [3:0]  exp_sel;

  // Compare DUT against the model on every falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      if (exp_zero) begin
        chk("rst_req", 32'(c_req), 32'd0);
        chk("rst_outs", 32'(|{c_req, c_we, c_wreg, c_stall, c_align, c_berr, c_addr, c_dw,
                              c_pc, c_wdata, c_sel, c_rw}), 32'd0);
      end else begin
        chk("req", 32'(c_req), 32'(exp_req));
        chk("stall", 32'(c_stall), 32'(exp_stall));
        chk("wreg", 32'(c_wreg), 32'(exp_wreg));
        chk("align", 32'(c_align), 32'(exp_align));
        chk("bus_err", 32'(c_berr), 32'(exp_err));
        if (exp_req) begin
          chk("we", 32'(c_we), 32'(exp_we));
          chk("dbus_addr", c_addr, exp_addr);
          chk("sel", 32'(c_sel), 32'(exp_sel));
          chk("dbus_wdata", c_dw, exp_dw);
        end
        if (exp_chk_wdata) chk("wb_wdata", c_wdata, exp_wdata);
        if (exp_chk_prw) begin
          chk("pc", c_pc, pc_i);
          chk("rw", 32'(c_rw), 32'(mem_rw_i));
        end
      end
    end
  end

  int          obs_cyc, obs_stall, obs_req;
  logic [31:0] obs_wdata, obs_addr, obs_dw;
  logic [3:0]  obs_sel;
  logic        obs_err, obs_we;

  task automatic obs_clear();
    obs_cyc = 0; obs_stall = 0; obs_req = 0; obs_wdata = '0;
    obs_addr = '0; obs_dw = '0; obs_sel = '0; obs_err = 1'b0; obs_we = 1'b0;
  endtask

  task automatic exp_clear();
    exp_zero = 1'b0; exp_req = 1'b0; exp_we = 1'b0; exp_stall = 1'b0; exp_wreg = 1'b0;
    exp_align = 1'b0; exp_err = 1'b0; exp_chk_wdata = 1'b0; exp_chk_prw = 1'b0;
    exp_addr = '0; exp_dw = '0; exp_wdata = '0; exp_sel = '0;
  endtask

  // One cycle: sample observations mid-cycle, then advance past the edge.
  task automatic step();
    @(negedge clk);
    obs_cyc++;
    if (c_stall) obs_stall++;
    if (c_req) begin
      obs_req++; obs_sel = c_sel; obs_addr = c_addr; obs_dw = c_dw; obs_we = c_we;
    end
    obs_wdata = c_wdata;
    obs_err   = c_berr;
    @(posedge clk);
    #1;
  endtask

  task automatic run_none(input logic [3:0] op, input logic [31:0] pc, input logic [4:0] rw,
                          input logic wreg, input logic [31:0] wd, input logic ack);
    mem_op_i = op; pc_i = pc; mem_rw_i = rw; mem_wreg_i = wreg; mem_wdata_i = wd;
    mem_addr_i = 32'h0000_0040; mem_sdata_i = '0; dbus_ack_i = ack;
    obs_clear(); exp_clear();
    exp_wreg = wreg; exp_wdata = wd; exp_chk_wdata = 1'b1; exp_chk_prw = 1'b1;
    step();
    dbus_ack_i = 1'b0;
  endtask

  // Full memory transaction: ack arrives after 'waits' wait cycles unless the
  // DUT's timeout expires first.
  task automatic run_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sd,
                        input logic [31:0] rd, input int waits);
    int  tmo = use_b ? 4 : 255;
    int  n;
    logic to;
    mem_op_i = op; mem_addr_i = addr; mem_sdata_i = sd; dbus_rdata_i = rd;
    pc_i = addr + 32'h1000; mem_rw_i = addr[6:2]; mem_wreg_i = 1'b1; mem_wdata_i = ~sd;
    dbus_ack_i = 1'b0;
    obs_clear(); exp_clear();
    if (m_misal(op, addr)) begin
      exp_align = 1'b1;
      step();
      return;
    end
    exp_stall = 1'b1;
    step();
    to = (waits + 1 > tmo);
    n  = to ? tmo : waits + 1;
    for (int i = 1; i <= n; i++) begin
      exp_req = 1'b1; exp_we = m_store(op); exp_addr = {addr[31:2], 2'b00};
      exp_sel = m_sel(op, addr); exp_dw = m_dwdata(op, sd); exp_stall = 1'b1;
      dbus_ack_i = !to && (i == n);
      step();
    end
    dbus_ack_i = 1'b0;
    exp_clear();
    exp_err = to; exp_wreg = !to; exp_chk_wdata = !to; exp_chk_prw = 1'b1;
    exp_wdata = m_store(op) ? mem_wdata_i : m_load(op, addr, rd);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; mem_op_i = 4'd0; pc_i = 32'h0; mem_rw_i = 5'd5; mem_wreg_i = 1'b1;
    mem_wdata_i = 32'h1234; mem_addr_i = '0; mem_sdata_i = '0; dbus_rdata_i = '0;
    dbus_ack_i = 1'b0;
    exp_clear(); obs_clear();
    chk_en = 1'b1; exp_zero = 1'b1;
    step(); step();

    // Model pins.
    chk("model_lb", m_load(4'd1, 32'h103, 32'hF0), 32'hFFFF_FFF0);
    chk("model_sel_sh", 32'(m_sel(4'd7, 32'h202)), 32'h3);
    chk("model_lh", m_load(4'd3, 32'h102, 32'h1234_8001), 32'hFFFF_8001);

    rst = 1'b1;
    run_none(4'd0, 32'h0, 5'd5, 1'b1, 32'h1234, 1'b0);
    chk("none_wdata", obs_wdata, 32'h1234);
    chk("none_stall", 32'(obs_stall), 32'd0);

    run_op(4'd1, 32'h103, 32'h0, 32'h0000_00F0, 0);
    chk("lb_stall_cyc", 32'(obs_stall), 32'd2);
    chk("lb_total_cyc", 32'(obs_cyc), 32'd3);
    chk("lb_sel", 32'(obs_sel), 32'b0001);
    chk("lb_data", obs_wdata, 32'hFFFF_FFF0);

    run_op(4'd2, 32'h103, 32'h0, 32'h0000_00F0, 0);
    chk("lbu_data", obs_wdata, 32'h0000_00F0);

    run_op(4'd7, 32'h202, 32'hABCD_1234, 32'h0, 4);
    chk("sh_we", 32'(obs_we), 32'd1);
    chk("sh_sel", 32'(obs_sel), 32'b0011);
    chk("sh_addr", obs_addr, 32'h200);
    chk("sh_wdata", obs_dw, 32'h1234_1234);
    chk("sh_total_cyc", 32'(obs_cyc), 32'd7);

    run_op(4'd5, 32'h101, 32'h0, 32'h0, 0);
    chk("lw_mis_req", 32'(obs_req), 32'd0);
    chk("lw_mis_stall", 32'(obs_stall), 32'd0);

    run_op(4'd3, 32'h102, 32'h0, 32'h1234_8001, 1);
    chk("lh_data", obs_wdata, 32'hFFFF_8001);
    run_op(4'd4, 32'h100, 32'h0, 32'hF00D_1234, 0);
    chk("lhu_data", obs_wdata, 32'h0000_F00D);
    run_op(4'd6, 32'h301, 32'h0000_0055, 32'h0, 1);
    chk("sb_sel", 32'(obs_sel), 32'b0100);
    chk("sb_wdata", obs_dw, 32'h5555_5555);
    run_op(4'd8, 32'h400, 32'h8765_4321, 32'h0, 0);
    run_op(4'd5, 32'h404, 32'h0, 32'hCAFE_BABE, 2);
    chk("lw_data", obs_wdata, 32'hCAFE_BABE);
    run_op(4'd7, 32'h205, 32'h1, 32'h0, 0);
    run_op(4'd4, 32'h103, 32'h0, 32'h0, 0);
    run_none(4'd12, 32'h88, 5'd9, 1'b1, 32'h5A5A_0000, 1'b0);
    run_none(4'd0, 32'h8C, 5'd10, 1'b0, 32'h7, 1'b1);

    // Reset falling mid-ACCESS.
    mem_op_i = 4'd5; mem_addr_i = 32'h500; pc_i = 32'h1500; mem_rw_i = 5'd1;
    mem_wreg_i = 1'b1; mem_wdata_i = '0; dbus_ack_i = 1'b0; dbus_rdata_i = 32'h9999_0000;
    exp_clear(); exp_stall = 1'b1;
    step();
    exp_req = 1'b1; exp_we = 1'b0; exp_addr = 32'h500; exp_sel = 4'hF; exp_dw = '0;
    step(); step();
    rst = 1'b0; exp_clear(); exp_zero = 1'b1; obs_clear();
    step();
    chk("midrst_req", 32'(obs_req), 32'd0);
    rst = 1'b1;
    run_none(4'd0, 32'h2000, 5'd3, 1'b1, 32'hAAAA_5555, 1'b1);
    chk("late_ack_req", 32'(obs_req), 32'd0);
    run_none(4'd0, 32'h2004, 5'd4, 1'b1, 32'h0BAD_F00D, 1'b1);
    chk("late_ack_wdata", obs_wdata, 32'h0BAD_F00D);

    // Short-timeout instance.
    rst = 1'b0; exp_clear(); exp_zero = 1'b1;
    step(); step();
    use_b = 1'b1; rst = 1'b1;
    run_op(4'd5, 32'h600, 32'h0, 32'h1111_1111, 100);
    chk("to_req_cyc", 32'(obs_req), 32'd4);
    chk("to_err", 32'(obs_err), 32'd1);
    chk("to_total_cyc", 32'(obs_cyc), 32'd6);
    run_op(4'd5, 32'h604, 32'h0, 32'h2222_3333, 3);
    chk("ack_wins_req", 32'(obs_req), 32'd4);
    chk("ack_wins_err", 32'(obs_err), 32'd0);
    chk("ack_wins_data", obs_wdata, 32'h2222_3333);
    run_op(4'd2, 32'h601, 32'h0, 32'h0080_0000, 2);
    chk("b_lbu_data", obs_wdata, 32'h0000_0080);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- Memory-access (MEM) stage sitting directly downstream of the EX/MEM pipeline register and upstream of MEM/WB.
- Non-memory instructions pass through combinationally with zero added latency.
- Loads and stores run a req/ack transaction on the data bus. The block raises a stall request while the transaction is outstanding.
- Produces sign/zero-extended load data, the writeback controls, and the misalignment and bus-timeout flags.

Parameters:
- TIMEOUT, 255: ACCESS-state cycles without dbus_ack_i before the access is aborted. Range 1..255.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset.
- pc_i  in  32  PC of the instruction in MEM.
- mem_rw_i  in  5  destination register.
- mem_wreg_i  in  1  register-write enable.
- mem_wdata_i  in  32  ALU result for non-memory ops.
- mem_op_i  in  4  0=NONE, 1=LB, 2=LBU, 3=LH, 4=LHU, 5=LW, 6=SB, 7=SH, 8=SW; other codes behave as NONE.
- mem_addr_i  in  32  effective byte address.
- mem_sdata_i  in  32  store data.
- dbus_req_o  out  1  bus request.
- dbus_we_o  out  1  1 = write.
- dbus_addr_o  out  32  word address, {mem_addr_i[31:2],2'b00}.
- dbus_sel_o  out  4  byte-lane enables, big-endian; sel[3] = byte at addr[1:0]=0.
- dbus_wdata_o  out  32  store data replicated to the selected lanes.
- dbus_rdata_i  in  32  read data.
- dbus_ack_i  in  1  transfer complete.
- pc_o  out  32  PC passed to writeback.
- wb_rw_o  out  5  destination register passed to writeback.
- wb_wreg_o  out  1  writeback enable.
- wb_wdata_o  out  32  writeback data.
- stall_req_o  out  1  freeze the stages up to and including EX/MEM.
- excp_align_o  out  1  misaligned-access flag.
- bus_err_o  out  1  bus-timeout flag.

Behaviour:

Reset:
- rst==0 at a clock edge: state<=IDLE, counter<=0, result reg<=0.
- While rst==0, every output is forced to 0.

Alignment and lane mapping:
- Misaligned: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0.
- Byte lanes: addr 0/1/2/3 -> sel 1000/0100/0010/0001.
- Halfword lanes: addr 0/2 -> 1100/0011.
- Word: 1111.
- Store data: SB puts sdata[7:0] on all four lanes; SH puts sdata[15:0] on both halves.

State IDLE:
- NONE: pc_o, wb_rw_o, wb_wreg_o, wb_wdata_o = inputs; stall_req_o=0.
- Misaligned memory op: no bus access; excp_align_o=1; wb_wreg_o=0; stall_req_o=0; stay in IDLE.
- Aligned memory op: stall_req_o=1; wb_wreg_o=0; next state ACCESS; counter<=0.

State ACCESS:
- dbus_req_o=1, dbus_we_o = store; addr, sel and wdata driven as above.
- stall_req_o=1; wb_wreg_o=0.
- Inputs are held stable by the stall.
- dbus_ack_i=1: capture the extended load lane into result reg; next state DONE.
- Extension: LB/LH sign-extend; LBU/LHU zero-extend.
- No ack: counter+1. When counter==TIMEOUT-1 with no ack, set the error flag and go to DONE.
- Ack in the same cycle as the timeout: ack wins, no error.

State DONE (exactly one cycle):
- stall_req_o=0; dbus_req_o=0.
- Load: wb_wdata_o=result reg, wb_wreg_o=mem_wreg_i.
- Store: wb_wreg_o=mem_wreg_i, wb_wdata_o=mem_wdata_i.
- Error: bus_err_o=1 and wb_wreg_o=0.
- Next state IDLE. The next instruction is evaluated in that IDLE cycle.

Latency and bus rules:
- Memory op takes 3+W cycles, where W = wait cycles before ack. Zero-wait minimum is 3.
- dbus_req_o is asserted only in ACCESS and is never dropped before ack or timeout.
- An ack seen outside ACCESS is ignored.

Reset mid-transaction:
- dbus_req_o goes low in the same cycle rst falls (output gating).
- State is IDLE after that edge; any late ack is ignored.

Test Plan:
- rst=0 for 2 cycles, then NONE op with wdata=0x1234, rw=5, wreg=1 -> all outputs 0 during reset; then wb_wdata_o=0x1234, wb_rw_o=5, stall_req_o=0 in the same cycle.
- LB at addr 0x103, ack immediate, rdata=0x000000F0 -> stall high for 2 cycles, sel=0001; DONE gives wb_wdata_o=0xFFFFFFF0. Repeat with LBU -> 0x000000F0.
- SH at addr 0x202, sdata=0xABCD1234 -> dbus_we_o=1, sel=0011, dbus_addr_o=0x200, wdata=0x12341234; ack after 4 waits -> total 7 cycles.
- LW at addr 0x101 -> excp_align_o=1, dbus_req_o never asserted, stall_req_o=0, wb_wreg_o=0.
- TIMEOUT=4, LW with no ack -> req held exactly 4 cycles; DONE: bus_err_o=1, wb_wreg_o=0. Repeat with ack in the 4th ACCESS cycle -> no error, data written.
- rst falls during ACCESS -> dbus_req_o=0 in that cycle; after the edge, state is IDLE; a subsequent ack has no effect.
